// File: rtl/dll_tx_tlp_ingress_if.sv
// TL transmit beat stream between the transaction layer and the DLL ingress.
interface dll_tx_tlp_ingress_if;
  logic [255:0] tlp;
  logic [2:0]   req;

  modport master (output tlp, output req);
  modport slave  (input tlp, input req);
endinterface

// File: rtl/dll_tx_tlp_ingress.sv
// DLL ingress of the TL transmit stream: frames TLPs, writes them into the retry buffer
// with a sequence-tagged header, commits descriptors and frees retry space on ACK.
//   state     | meaning
//   S_IDLE    | between TLPs, waiting for a header code
//   S_HDR_P   | posted TLP open, P_DATA beats accepted
//   S_HDR_CPL | completion open, CPL_DATA beats accepted
//   S_HDR_NP  | non-posted TLP open, header only
module dll_tx_tlp_ingress #(
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int DESC_DEPTH_LG2  = 4,
  parameter int MAX_TLP_BEATS   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dll_tx_tlp_ingress_if.slave          tl,
  input  logic                         link_active_i,
  input  logic                         ack_en_i,
  input  logic [11:0]                  ack_seq_i,
  output logic                         rb_wren_o,
  output logic [RETRY_DEPTH_LG2-1:0]   rb_waddr_o,
  output logic [255:0]                 rb_wdata_o,
  output logic                         commit_o,
  output logic [11:0]                  commit_seq_o,
  output logic [RETRY_DEPTH_LG2-1:0]   commit_addr_o,
  output logic [2:0]                   commit_len_o,
  // one extra bit so a completely empty buffer (DEPTH*8 DW) is representable
  output logic [RETRY_DEPTH_LG2+3:0]   retry_buffer_leftover_cnt_o,
  output logic                         proto_err_o,
  output logic                         ovf_err_o
);

  localparam int CW         = RETRY_DEPTH_LG2 + 1;
  localparam int DESC_DEPTH = 1 << DESC_DEPTH_LG2;

  localparam logic [CW-1:0]                DEPTH_C   = CW'(1 << RETRY_DEPTH_LG2);
  localparam logic [RETRY_DEPTH_LG2+3:0]   LEFT_FULL = {DEPTH_C, 3'b000};
  localparam logic [2:0]                   MAX_C     = 3'(MAX_TLP_BEATS);
  localparam logic [RETRY_DEPTH_LG2-1:0]   ADDR_ONE  = RETRY_DEPTH_LG2'(1);
  localparam logic [DESC_DEPTH_LG2-1:0]    DPTR_ONE  = DESC_DEPTH_LG2'(1);
  localparam logic [DESC_DEPTH_LG2:0]      DCNT_ONE  = (DESC_DEPTH_LG2+1)'(1);
  localparam logic [DESC_DEPTH_LG2:0]      DCNT_FULL = (DESC_DEPTH_LG2+1)'(DESC_DEPTH);

  localparam logic [2:0] REQ_IDLE     = 3'd0;
  localparam logic [2:0] REQ_P_HDR    = 3'd1;
  localparam logic [2:0] REQ_P_DATA   = 3'd2;
  localparam logic [2:0] REQ_NP_HDR   = 3'd3;
  localparam logic [2:0] REQ_CPL_HDR  = 3'd5;
  localparam logic [2:0] REQ_CPL_DATA = 3'd6;
  localparam logic [2:0] REQ_DONE     = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_HDR_P, S_HDR_CPL, S_HDR_NP} state_t;

  state_t                      state, state_nxt;
  logic [RETRY_DEPTH_LG2-1:0]  wptr, tlp_start, waddr;
  logic [11:0]                 next_seq, acked_seq, ack_dist;
  logic [2:0]                  inflight;
  logic [CW-1:0]               committed_cnt, free_rewind, free_cnt;

  logic [11:0]                 desc_seq [DESC_DEPTH];
  logic [2:0]                  desc_len [DESC_DEPTH];
  logic [DESC_DEPTH_LG2-1:0]   desc_rd, desc_wr;
  logic [DESC_DEPTH_LG2:0]     desc_cnt;
  logic                        desc_full, pop;

  logic is_hdr, data_ok;
  logic act_write, act_hdr, act_commit, act_drop, act_proto, act_ovf;

  function automatic state_t hdr_state(input logic [2:0] r);
    case (r)
      REQ_P_HDR:   return S_HDR_P;
      REQ_CPL_HDR: return S_HDR_CPL;
      default:     return S_HDR_NP;
    endcase
  endfunction

  assign free_rewind = DEPTH_C - committed_cnt;
  assign free_cnt    = free_rewind - CW'(inflight);
  assign desc_full   = (desc_cnt == DCNT_FULL);
  // distance modulo 4096; the top bit set means the head is still ahead of the ACK
  assign ack_dist    = acked_seq - desc_seq[desc_rd];
  assign pop         = (desc_cnt != '0) && !ack_dist[11];

  assign is_hdr  = (tl.req == REQ_P_HDR) || (tl.req == REQ_NP_HDR) || (tl.req == REQ_CPL_HDR);
  assign data_ok = ((state == S_HDR_P)   && (tl.req == REQ_P_DATA)) ||
                   ((state == S_HDR_CPL) && (tl.req == REQ_CPL_DATA));
  assign waddr   = act_drop ? tlp_start : wptr;

  always_comb begin
    state_nxt  = state;
    act_write  = 1'b0;
    act_hdr    = 1'b0;
    act_commit = 1'b0;
    act_drop   = 1'b0;
    act_proto  = 1'b0;
    act_ovf    = 1'b0;
    if (tl.req != REQ_IDLE) begin
      if (state == S_IDLE) begin
        if (is_hdr) begin
          if (free_cnt == '0) begin
            act_ovf = 1'b1;
          end else begin
            act_write = 1'b1;
            act_hdr   = 1'b1;
            state_nxt = hdr_state(tl.req);
          end
        end else begin
          act_proto = 1'b1;
        end
      end else if (tl.req == REQ_DONE) begin
        state_nxt = S_IDLE;
        if (desc_full) begin
          act_ovf  = 1'b1;
          act_drop = 1'b1;
        end else begin
          act_commit = 1'b1;
        end
      end else if (data_ok) begin
        if ((inflight == MAX_C) || (free_cnt == '0)) begin
          act_ovf   = 1'b1;
          act_drop  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          act_write = 1'b1;
        end
      end else begin
        // a header here abandons the open TLP and opens a new one at its start address
        act_proto = 1'b1;
        act_drop  = 1'b1;
        state_nxt = S_IDLE;
        if (is_hdr) begin
          if (free_rewind == '0) begin
            act_ovf = 1'b1;
          end else begin
            act_write = 1'b1;
            act_hdr   = 1'b1;
            state_nxt = hdr_state(tl.req);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !link_active_i) begin
      state                       <= S_IDLE;
      wptr                        <= '0;
      tlp_start                   <= '0;
      next_seq                    <= '0;
      acked_seq                   <= 12'hFFF;
      inflight                    <= '0;
      committed_cnt               <= '0;
      desc_rd                     <= '0;
      desc_wr                     <= '0;
      desc_cnt                    <= '0;
      rb_wren_o                   <= 1'b0;
      commit_o                    <= 1'b0;
      proto_err_o                 <= 1'b0;
      ovf_err_o                   <= 1'b0;
      retry_buffer_leftover_cnt_o <= LEFT_FULL;
      if (!rst_n) begin
        rb_waddr_o    <= '0;
        rb_wdata_o    <= '0;
        commit_seq_o  <= '0;
        commit_addr_o <= '0;
        commit_len_o  <= '0;
      end
    end else begin
      state                       <= state_nxt;
      rb_wren_o                   <= act_write;
      commit_o                    <= act_commit;
      proto_err_o                 <= act_proto;
      ovf_err_o                   <= act_ovf;
      retry_buffer_leftover_cnt_o <= {free_cnt, 3'b000};
      if (ack_en_i) acked_seq <= ack_seq_i;

      if (act_write) begin
        rb_waddr_o <= waddr;
        rb_wdata_o <= act_hdr ? {tl.tlp[255:140], next_seq, tl.tlp[127:0]} : tl.tlp;
        wptr       <= waddr + ADDR_ONE;
        inflight   <= (act_drop ? 3'd0 : inflight) + 3'd1;
      end else if (act_drop) begin
        wptr     <= tlp_start;
        inflight <= '0;
      end

      if (act_commit) begin
        commit_seq_o  <= next_seq;
        commit_addr_o <= tlp_start;
        commit_len_o  <= inflight;
        tlp_start     <= wptr;
        inflight      <= '0;
        next_seq      <= next_seq + 12'd1;
        desc_wr       <= desc_wr + DPTR_ONE;
      end

      if (pop) desc_rd <= desc_rd + DPTR_ONE;
      case ({act_commit, pop})
        2'b10:   desc_cnt <= desc_cnt + DCNT_ONE;
        2'b01:   desc_cnt <= desc_cnt - DCNT_ONE;
        default: desc_cnt <= desc_cnt;
      endcase

      committed_cnt <= committed_cnt
                       + (act_commit ? CW'(inflight) : '0)
                       - (pop ? CW'(desc_len[desc_rd]) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && link_active_i && act_commit) begin
      desc_seq[desc_wr] <= next_seq;
      desc_len[desc_wr] <= inflight;
    end
  end

endmodule

// File: tb/tb_dll_tx_tlp_ingress.sv
// Scoreboard bench for dll_tx_tlp_ingress: directed TLP sequences on a default-size instance,
// plus a small-buffer instance to reach the retry-full overflow.
module tb_dll_tx_tlp_ingress;

  localparam logic [2:0] P_HDR = 3'd1, P_DATA = 3'd2, NP_HDR = 3'd3, RSVD = 3'd4,
                         CPL_HDR = 3'd5, CPL_DATA = 3'd6, DONE = 3'd7;
  localparam logic [1:0] E_PROTO = 2'b10, E_OVF = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_active = 1'b1;
  logic ack_en = 1'b0;
  logic [11:0] ack_seq = '0;
  always #5 clk = ~clk;

  dll_tx_tlp_ingress_if tl_if ();
  dll_tx_tlp_ingress_if sm_if ();

  logic         rb_wren, commit, proto_err, ovf_err;
  logic [7:0]   rb_waddr, commit_addr;
  logic [255:0] rb_wdata;
  logic [11:0]  commit_seq;
  logic [2:0]   commit_len;
  logic [11:0]  leftover;

  dll_tx_tlp_ingress u_dut (
    .clk(clk), .rst_n(rst_n), .tl(tl_if),
    .link_active_i(link_active), .ack_en_i(ack_en), .ack_seq_i(ack_seq),
    .rb_wren_o(rb_wren), .rb_waddr_o(rb_waddr), .rb_wdata_o(rb_wdata),
    .commit_o(commit), .commit_seq_o(commit_seq), .commit_addr_o(commit_addr),
    .commit_len_o(commit_len), .retry_buffer_leftover_cnt_o(leftover),
    .proto_err_o(proto_err), .ovf_err_o(ovf_err)
  );

  logic         sm_link = 1'b1, sm_ack_en = 1'b0;
  logic [11:0]  sm_ack_seq = '0;
  logic         sm_wren, sm_commit, sm_proto, sm_ovf;
  logic [2:0]   sm_waddr, sm_caddr, sm_clen;
  logic [255:0] sm_wdata;
  logic [11:0]  sm_cseq;
  logic [6:0]   sm_left;

  dll_tx_tlp_ingress #(.RETRY_DEPTH_LG2(3)) u_small (
    .clk(clk), .rst_n(rst_n), .tl(sm_if),
    .link_active_i(sm_link), .ack_en_i(sm_ack_en), .ack_seq_i(sm_ack_seq),
    .rb_wren_o(sm_wren), .rb_waddr_o(sm_waddr), .rb_wdata_o(sm_wdata),
    .commit_o(sm_commit), .commit_seq_o(sm_cseq), .commit_addr_o(sm_caddr),
    .commit_len_o(sm_clen), .retry_buffer_leftover_cnt_o(sm_left),
    .proto_err_o(sm_proto), .ovf_err_o(sm_ovf)
  );

  typedef struct packed { logic [7:0] addr; logic [255:0] data; } wr_t;
  typedef struct packed { logic [11:0] seq; logic [7:0] addr; logic [2:0] len; } cm_t;
  wr_t        wr_q [$];
  cm_t        cm_q [$];
  logic [1:0] err_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  wr_t        mw;
  cm_t        mc;
  logic [1:0] me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rb_wren) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h, no write expected", rb_waddr);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", 256'(rb_waddr), 256'(mw.addr));
          chk("wr_data", rb_wdata, mw.data);
        end
      end
      if (commit) begin
        if (cm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: seq %0d, no commit expected", commit_seq);
        end else begin
          mc = cm_q.pop_front();
          chk("commit_seq", 256'(commit_seq), 256'(mc.seq));
          chk("commit_addr", 256'(commit_addr), 256'(mc.addr));
          chk("commit_len", 256'(commit_len), 256'(mc.len));
        end
      end
      if (proto_err || ovf_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_error: proto %0b ovf %0b", proto_err, ovf_err);
        end else begin
          me = err_q.pop_front();
          chk("err_kind", 256'({proto_err, ovf_err}), 256'(me));
        end
      end
    end
  end

  int         sm_wr_cnt = 0, sm_ovf_cnt = 0, sm_proto_cnt = 0, sm_cm_cnt = 0;
  logic [2:0] sm_last_waddr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (sm_wren) begin sm_wr_cnt++; sm_last_waddr = sm_waddr; end
      if (sm_ovf) sm_ovf_cnt++;
      if (sm_proto) sm_proto_cnt++;
      if (sm_commit) sm_cm_cnt++;
    end
  end

  // bench-side reference of the write pointer / sequence bookkeeping
  logic [7:0]  m_wptr = '0, m_start = '0;
  logic [11:0] m_seq = '0;
  logic [2:0]  m_len = '0;
  int          beat_n = 0;

  function automatic logic [255:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA5C3_0000 ^ 32'(n);
    return {w, ~w, w + 32'd1, w ^ 32'hFFFF, w, ~w, w - 32'd7, w};
  endfunction

  task automatic drive(input logic [2:0] r, input logic [255:0] d, input logic ae, input logic [11:0] as);
    @(posedge clk); #1;
    tl_if.req = r; tl_if.tlp = d; ack_en = ae; ack_seq = as;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(3'd0, '0, 1'b0, '0);
  endtask

  task automatic ack(input logic [11:0] s);
    drive(3'd0, '0, 1'b1, s);
  endtask

  task automatic hdr(input logic [2:0] code);
    logic [255:0] d;
    wr_t w;
    d = pat(beat_n++);
    w.addr = m_wptr;
    w.data = {d[255:140], m_seq, d[127:0]};
    wr_q.push_back(w);
    m_start = m_wptr;
    m_wptr++;
    m_len = 3'd1;
    drive(code, d, 1'b0, '0);
  endtask

  task automatic dat(input logic [2:0] code);
    wr_t w;
    w.addr = m_wptr;
    w.data = pat(beat_n++);
    wr_q.push_back(w);
    m_wptr++;
    m_len++;
    drive(code, w.data, 1'b0, '0);
  endtask

  task automatic done();
    cm_t c;
    c.seq = m_seq; c.addr = m_start; c.len = m_len;
    cm_q.push_back(c);
    m_seq++;
    m_len = '0;
    m_start = m_wptr;
    drive(DONE, pat(beat_n++), 1'b0, '0);
  endtask

  task automatic bad(input logic [2:0] code, input logic [1:0] kind);
    err_q.push_back(kind);
    m_wptr = m_start;
    m_len = '0;
    drive(code, pat(beat_n++), 1'b0, '0);
  endtask

  task automatic restart(input logic [2:0] code);
    err_q.push_back(E_PROTO);
    m_wptr = m_start;
    hdr(code);
  endtask

  task automatic check_left(input string name, input logic [11:0] exp);
    idle(4);
    chk(name, 256'(leftover), 256'(exp));
  endtask

  task automatic flush(input int n);
    @(posedge clk); #1;
    link_active = 1'b0;
    tl_if.req = P_HDR; tl_if.tlp = pat(beat_n++); ack_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("flush_leftover", 256'(leftover), 256'(12'd2048));
    end
    link_active = 1'b1;
    tl_if.req = 3'd0;
    m_wptr = '0; m_start = '0; m_seq = '0; m_len = '0;
  endtask

  task automatic sdrive(input logic [2:0] r);
    @(posedge clk); #1;
    sm_if.req = r; sm_if.tlp = pat(beat_n++); sm_ack_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tl_if.req = '0; tl_if.tlp = '0;
    sm_if.req = '0; sm_if.tlp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wren", 256'(rb_wren), 256'(0));
    chk("rst_commit", 256'(commit), 256'(0));
    chk("rst_errs", 256'({proto_err, ovf_err}), 256'(0));
    chk("rst_leftover", 256'(leftover), 256'(12'd2048));
    chk("rst_sm_leftover", 256'(sm_left), 256'(7'd64));
    rst_n = 1'b1;

    // small instance: 8-entry buffer filled by a 5-beat and a 3-beat TLP
    sdrive(P_HDR); repeat (4) sdrive(P_DATA); sdrive(DONE);
    sdrive(P_HDR); repeat (2) sdrive(P_DATA); sdrive(DONE);
    sdrive(P_HDR);
    repeat (4) sdrive(3'd0);
    chk("sm_writes_full", 256'(sm_wr_cnt), 256'(8));
    chk("sm_ovf_full", 256'(sm_ovf_cnt), 256'(1));
    chk("sm_proto_none", 256'(sm_proto_cnt), 256'(0));
    chk("sm_left_full", 256'(sm_left), 256'(7'd0));
    @(posedge clk); #1; sm_ack_en = 1'b1; sm_ack_seq = 12'd0;
    repeat (4) sdrive(3'd0);
    chk("sm_left_ack0", 256'(sm_left), 256'(7'd40));
    sdrive(NP_HDR); sdrive(DONE);
    repeat (3) sdrive(3'd0);
    chk("sm_wrap_addr", 256'(sm_last_waddr), 256'(3'd0));
    chk("sm_commits", 256'(sm_cm_cnt), 256'(3));

    // 5-beat posted TLP
    hdr(P_HDR); repeat (4) dat(P_DATA); done();
    check_left("left_after_p5", 12'd2008);
    ack(12'd0);
    check_left("left_ack0", 12'd2048);

    // header-only NP TLP
    hdr(NP_HDR); done();
    check_left("left_after_np", 12'd2040);
    ack(12'd1);
    check_left("left_ack1", 12'd2048);

    // wrong data code in a posted TLP, then reuse of the same seq and address
    hdr(P_HDR); bad(CPL_DATA, E_PROTO);
    check_left("left_after_proto", 12'd2048);
    hdr(NP_HDR); done(); ack(m_seq - 12'd1);

    // header inside an open TLP restarts it
    hdr(P_HDR); dat(P_DATA); restart(NP_HDR); done(); ack(m_seq - 12'd1);

    // illegal codes from idle, no-op idles inside a TLP
    bad(P_DATA, E_PROTO); bad(DONE, E_PROTO); bad(RSVD, E_PROTO);
    hdr(P_HDR); idle(1); dat(P_DATA); idle(1); done(); ack(m_seq - 12'd1);

    // sixth beat exceeds the TLP limit
    hdr(P_HDR); repeat (4) dat(P_DATA); bad(P_DATA, E_OVF);
    check_left("left_after_beat_ovf", 12'd2048);
    hdr(NP_HDR); done(); ack(m_seq - 12'd1);

    // data in a non-posted TLP, then a completion
    hdr(NP_HDR); bad(P_DATA, E_PROTO);
    hdr(CPL_HDR); dat(CPL_DATA); done(); ack(m_seq - 12'd1);

    // descriptor FIFO full
    repeat (16) begin hdr(NP_HDR); done(); end
    hdr(NP_HDR); bad(DONE, E_OVF);
    check_left("left_desc_full", 12'd1920);
    ack(m_seq - 12'd1);
    idle(20);
    chk("left_desc_drained", 256'(leftover), 256'(12'd2048));
    hdr(NP_HDR); done(); ack(m_seq - 12'd1);
    check_left("left_before_flush", 12'd2048);

    // link drop mid-TLP
    hdr(P_HDR); dat(P_DATA);
    flush(4);
    hdr(NP_HDR); done();
    check_left("left_post_flush", 12'd2040);
    ack(12'd0);
    check_left("left_post_flush_ack", 12'd2048);

    // sequence number wrap
    flush(2);
    for (int i = 0; i < 4096; i++) begin
      hdr(NP_HDR); done(); ack(12'(i));
    end
    check_left("left_wrap_drained", 12'd2048);
    hdr(NP_HDR); done(); ack(12'd4095);
    check_left("left_wrap_seq0_held", 12'd2040);
    ack(12'd0);
    check_left("left_wrap_seq0_acked", 12'd2048);

    idle(5);
    chk("wr_q_drained", 256'(wr_q.size()), 256'(0));
    chk("cm_q_drained", 256'(cm_q.size()), 256'(0));
    chk("err_q_drained", 256'(err_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
